// File: rtl/mesh_skew_feeder_if.sv
// Beat-in / skewed-rows-out bundle for the systolic mesh feeder.
// master drives beats and watches the mesh side; slave is the feeder.
interface mesh_skew_feeder_if #(
  parameter int ROWS = 8,
  parameter int W    = 8,
  parameter int SHW  = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic [ROWS*W-1:0]    in_a;
  logic [ROWS*W-1:0]    in_d;
  logic [ROWS*W-1:0]    in_b;
  logic                 in_propagate;
  logic [SHW-1:0]       in_shift;
  logic [ROWS-1:0]      out_valid;
  logic [ROWS*W-1:0]    out_a;
  logic [ROWS*W-1:0]    out_d;
  logic [ROWS*W-1:0]    out_b;
  logic [ROWS-1:0]      out_propagate;
  logic [ROWS*SHW-1:0]  out_shift;
  logic                 tile_done;
  logic [15:0]          tile_beats;

  modport master (
    output in_valid, in_last, in_a, in_d, in_b,
    output in_propagate, in_shift,
    input  in_ready, out_valid, out_a, out_d, out_b,
    input  out_propagate, out_shift, tile_done, tile_beats
  );

  modport slave (
    input  in_valid, in_last, in_a, in_d, in_b,
    input  in_propagate, in_shift,
    output in_ready, out_valid, out_a, out_d, out_b,
    output out_propagate, out_shift, tile_done, tile_beats
  );
endinterface

// File: rtl/mesh_skew_feeder.sv
// Skews row-vector beats diagonally into the mesh rows and
// holds off the next tile until the previous one has drained.
module mesh_skew_feeder #(
  parameter int ROWS = 8,
  parameter int W    = 8,
  parameter int SHW  = 5
) (
  input logic               CLK,
  input logic               RST,
  mesh_skew_feeder_if.slave bus
);
  localparam int CW = (ROWS > 2) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  state_t        state;
  logic [CW-1:0] dcnt;
  logic [15:0]   bcnt;
  logic [15:0]   pend;
  logic [15:0]   bnext;
  logic [15:0]   beats_q;
  logic          done_q;
  logic          acc;

  assign bus.in_ready   = !RST && (state != DRAIN);
  assign acc            = bus.in_valid && bus.in_ready;
  assign bnext          = (bcnt == 16'hFFFF) ? bcnt
                                             : bcnt + 16'd1;
  assign bus.tile_done  = done_q;
  assign bus.tile_beats = beats_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      dcnt    <= '0;
      bcnt    <= '0;
      pend    <= '0;
      beats_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (acc) begin
        bcnt <= bus.in_last ? 16'd0 : bnext;
        if (bus.in_last) pend <= bnext;
      end
      unique case (state)
        IDLE, STREAM: begin
          if (acc) begin
            state <= bus.in_last ? DRAIN : STREAM;
            dcnt  <= CW'(ROWS - 2);
          end
        end
        DRAIN: begin
          // Leaves exactly as the last beat exits the final row.
          if (dcnt == '0) begin
            state   <= IDLE;
            done_q  <= 1'b1;
            beats_q <= pend;
          end else begin
            dcnt <= dcnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [r:0]          v;
    logic [r:0]          p;
    logic [r:0][W-1:0]   a;
    logic [r:0][W-1:0]   d;
    logic [r:0][W-1:0]   b;
    logic [r:0][SHW-1:0] s;

    always_ff @(posedge CLK) begin
      if (RST) begin
        v <= '0;
        p <= '0;
        a <= '0;
        d <= '0;
        b <= '0;
        s <= '0;
      end else begin
        // Bubbles enter as all-zero so the mesh never sees stale data.
        v[0] <= acc;
        p[0] <= acc & bus.in_propagate;
        a[0] <= acc ? bus.in_a[r*W +: W] : '0;
        d[0] <= acc ? bus.in_d[r*W +: W] : '0;
        b[0] <= acc ? bus.in_b[r*W +: W] : '0;
        s[0] <= acc ? bus.in_shift : '0;
        for (int k = 1; k <= r; k++) begin
          v[k] <= v[k-1];
          p[k] <= p[k-1];
          a[k] <= a[k-1];
          d[k] <= d[k-1];
          b[k] <= b[k-1];
          s[k] <= s[k-1];
        end
      end
    end

    assign bus.out_valid[r]              = v[r];
    assign bus.out_propagate[r]          = p[r];
    assign bus.out_a[r*W +: W]           = a[r];
    assign bus.out_d[r*W +: W]           = d[r];
    assign bus.out_b[r*W +: W]           = b[r];
    assign bus.out_shift[r*SHW +: SHW]   = s[r];
  end
endmodule

// File: doc/mesh_skew_feeder.md
# mesh_skew_feeder

Upstream feeder for the 8×8 CPAF systolic mesh wrapper. It accepts one row-vector beat per cycle through a valid/ready handshake. Each beat carries per-row a, d and b operands plus the tile's propagate/shift control. It presents the beat to the mesh input rows in diagonal (skewed) order: row r sees the beat r+1 cycles after acceptance. It also enforces a drain gap between tiles so skewed tiles never overlap inside the mesh.

## Interface
Parameters:
- ROWS, 8, number of mesh rows fed (≥2)
- W, 8, operand width of a, d, b
- SHW, 5, width of shift control

Ports:
- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  reset, synchronous, active-high
- in_valid  input  1  beat offered
- in_ready  output  1  beat accepted when in_valid & in_ready
- in_last  input  1  accepted beat is the final beat of its tile
- in_a  input  ROWS*W  a operand; row r at [r*W +: W]
- in_d  input  ROWS*W  d operand, same packing
- in_b  input  ROWS*W  b operand, same packing
- in_propagate  input  1  tile propagate control
- in_shift  input  SHW  tile shift control
- out_valid  output  ROWS  per-row valid to the mesh
- out_a, out_d, out_b  output  ROWS*W  skewed operands, same packing
- out_propagate  output  ROWS  per-row propagate
- out_shift  output  ROWS*SHW  per-row shift
- tile_done  output  1  one-cycle pulse when the last beat of a tile leaves row ROWS-1
- tile_beats  output  16  beat count of the most recently completed tile

## Operation
- Row r has a delay line of r+1 register stages. Each stage holds {valid, a_r, d_r, b_r, propagate, shift}. Stage 0 of every row loads from the input every cycle.
- On an accepted beat, stage 0 loads valid=1 and the beat's fields. On any non-accepting cycle, stage 0 loads valid=0 and all fields 0. Bubbles therefore arrive at the mesh as zeros.
- The pipeline never stalls. The mesh has no backpressure.
- FSM states:
  - IDLE: no tile open. in_ready=1. An accepted beat goes to STREAM. If that beat has in_last=1, it goes directly to DRAIN.
  - STREAM: tile open. in_ready=1. An accepted beat with in_last=1 goes to DRAIN.
  - DRAIN: in_ready=0. A counter loads ROWS-2 on entry and decrements each cycle. At count 0 the FSM returns to IDLE on the next edge.
- in_last is ignored unless the beat is accepted.
- Beat counter:
  - Increments on each accepted beat, saturating at 16'hFFFF.
  - On the accept of the in_last beat, the final count (including that beat, saturated) is latched for tile_beats.
  - The counter clears to 0 when the in_last beat is accepted.
- tile_beats updates in the same cycle tile_done pulses. It holds its value until the next tile_done.
- Control travels with data, so propagate/shift changes between tiles reach each row exactly with that row's first beat of the new tile.

## Timing
- Beat accepted at edge t:
  - Row r's out_* show the beat after edge t+1+r.
  - Row 0 shows it after edge t+1; row ROWS-1 shows it after edge t+ROWS.
- Last beat accepted at edge t:
  - in_ready=0 after edges t+1 … t+ROWS-1.
  - in_ready=1 again after edge t+ROWS.
  - tile_done=1 only after edge t+ROWS, coinciding with row ROWS-1's out_valid for that beat.
  - A beat accepted at t+ROWS reaches row 0 after edge t+ROWS+1. The gap is exactly ROWS-1 bubble cycles at row 0.
- in_ready is combinational from state and RST: in_ready = !RST && state!=DRAIN.
- Reset: while RST=1 at an edge, the following are cleared, and this includes mid-DRAIN or mid-tile:
  - all delay stages cleared
  - FSM to IDLE
  - drain counter 0
  - beat counter 0
  - tile_beats 0
  - tile_done 0
- After reset, all outputs are 0 and in_ready=0 during the RST cycle. A tile interrupted by reset is discarded and never produces tile_done.

## Test plan
- Single beat, ROWS=8, in_a row r = r+1, in_last=1 at edge 0:
  - out_valid is one-hot, walking bit r after edge r+1.
  - out_a row r = r+1 at that time, 0 otherwise.
  - tile_done after edge 8, tile_beats=1.
  - in_ready low after edges 1–7.
- Four back-to-back beats, propagate=1, shift=5'd3, last on beat 4:
  - Each row sees 4 consecutive valids starting at cycle r+1, carrying propagate=1 and shift=3.
  - tile_done after edge 11 (3+8), tile_beats=4.
- Two tiles with propagate 0 then 1, in_valid held high throughout:
  - Second tile's first accept occurs exactly 8 cycles after the first tile's last accept.
  - Row 7 sees no overlap, and propagate flips exactly with its first beat of tile 2.
- Intermittent in_valid (1,0,1,1,0,1 with last on the final beat):
  - Each row reproduces the pattern shifted by r+1, with zero data on bubbles.
  - tile_beats=4.
- RST asserted 3 cycles into DRAIN:
  - All outputs 0 after the reset edge, no tile_done, tile_beats=0.
  - in_ready=1 the cycle after RST deasserts.
- 65540 accepted beats in one tile: tile_beats saturates at 16'hFFFF.
